// File: rtl/hc_pkg.sv
// Shared definitions for the parametrised HC stack CPU: opcode fields,
// ALU operation codes, jump conditions and the core FSM states.
package hc_pkg;

    // Core sequencing states
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } state_e;

    // Major opcodes (instruction bits [7:4]) for the non-ALU group
    localparam logic [3:0] MAJ_LD   = 4'b1000;
    localparam logic [3:0] MAJ_LDX  = 4'b1001;
    localparam logic [3:0] MAJ_LI   = 4'b1010;
    localparam logic [3:0] MAJ_POP  = 4'b1011;
    localparam logic [3:0] MAJ_HALT = 4'b1100;
    localparam logic [3:0] MAJ_NOP  = 4'b1101;

    // ALU operation codes (instruction bits [6:4] when bit 7 is clear)
    localparam logic [2:0] ALU_MOV = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_NOT = 3'b110;
    localparam logic [2:0] ALU_SHL = 3'b111;

    // Jump condition codes (instruction bits [2:1])
    localparam logic [1:0] JC_ALWAYS = 2'b00;
    localparam logic [1:0] JC_CARRY  = 2'b01;
    localparam logic [1:0] JC_ZERO   = 2'b10;
    localparam logic [1:0] JC_NZERO  = 2'b11;

    // Only ADD, SUB and SHL are allowed to touch the carry flag
    function automatic logic alu_sets_carry(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SHL);
    endfunction

endpackage

// File: rtl/hc_alu_p.sv
// Combinational ALU for the HC core. Operates on A (top of stack) and
// B (second level); carry is the ADD carry-out, SUB borrow, or SHL shift-out.
module hc_alu_p
    import hc_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Extended add/subtract so the top bit is carry-out / borrow
    always_comb begin
        sum  = {1'b0, b} + {1'b0, a};
        diff = {1'b0, b} - {1'b0, a};
    end

    // Operation select
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_MOV: result = a;
            ALU_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            ALU_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            ALU_AND: result = b & a;
            ALU_OR:  result = b | a;
            ALU_XOR: result = b ^ a;
            ALU_NOT: result = ~a;
            ALU_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/hc_core_p.sv
// Parametrised HC stack CPU core. Instruction and data memories sit outside
// the core behind req/ack handshakes; a FETCH/EXEC/MEM/HALTED FSM sequences
// each instruction so memories may insert any number of wait states.
module hc_core_p
    import hc_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int STACK_D = 3,
    parameter int PC_W    = 12,
    parameter int DADDR_W = 8
) (
    input  logic               clk,
    input  logic               nReset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [7:0]         imem_rdata,
    input  logic               imem_ack,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic [PC_W-1:0]    pc_out,
    output logic [7:0]         instruction_out,
    output logic [DATA_W-1:0]  alu_out,
    output logic               halted
);

    // Widths used to fit {C,B,A} into the pc and {B,A} into a data address
    localparam int JW = (3 * DATA_W > PC_W) ? 3 * DATA_W : PC_W;
    localparam int XW = (2 * DATA_W > DADDR_W) ? 2 * DATA_W : DADDR_W;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   stk_q [STACK_D];
    logic [DATA_W-1:0]   stk_d [STACK_D];
    logic                c_q, c_d;
    logic                z_q, z_d;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     jmp_target;
    logic [JW-1:0]       cba_ext;
    logic [XW-1:0]       ba_ext;
    logic                is_store;
    logic                taken;
    logic                push_en;
    logic                pop_en;
    logic [DATA_W-1:0]   push_val;

    hc_alu_p #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (stk_q[0]),
        .b      (stk_q[1]),
        .op     (ir_q[6:4]),
        .result (alu_res),
        .carry  (alu_carry)
    );

    // Address/target formation and jump condition evaluation
    always_comb begin
        is_store   = ~ir_q[7];
        pc_inc     = pc_q + PC_W'(1);
        cba_ext    = JW'({stk_q[2], stk_q[1], stk_q[0]});
        jmp_target = cba_ext[PC_W-1:0];
        ba_ext     = XW'({stk_q[1], stk_q[0]});
        case (ir_q[2:1])
            JC_ALWAYS: taken = 1'b1;
            JC_CARRY:  taken = c_q;
            JC_ZERO:   taken = z_q;
            default:   taken = ~z_q;
        endcase
    end

    // Memory interface outputs; stable through MEM because nothing commits there until ack
    always_comb begin
        imem_req        = (state_q == FETCH);
        imem_addr       = pc_q;
        dmem_req        = (state_q == MEM);
        dmem_we         = (state_q == MEM) && is_store;
        dmem_addr       = (ir_q[7:4] == MAJ_LDX) ? ba_ext[DADDR_W-1:0] : DADDR_W'(ir_q[3:0]);
        dmem_wdata      = alu_res;
        pc_out          = pc_q;
        instruction_out = ir_q;
        alu_out         = alu_res;
        halted          = (state_q == HALTED);
    end

    // FSM next state, pc, flag and stack-operation decode
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        c_d      = c_q;
        z_d      = z_q;
        push_en  = 1'b0;
        pop_en   = 1'b0;
        push_val = '0;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_store) begin
                    state_d = MEM;
                end else begin
                    case (ir_q[7:4])
                        MAJ_LD, MAJ_LDX: state_d = MEM;
                        MAJ_LI: begin
                            push_en  = 1'b1;
                            push_val = DATA_W'(ir_q[3:0]);
                            pc_d     = pc_inc;
                            state_d  = FETCH;
                        end
                        MAJ_POP: begin
                            pop_en  = 1'b1;
                            pc_d    = pc_inc;
                            state_d = FETCH;
                        end
                        MAJ_HALT: state_d = HALTED;
                        MAJ_NOP: begin
                            pc_d    = pc_inc;
                            state_d = FETCH;
                        end
                        default: begin
                            pc_d    = taken ? jmp_target : pc_inc;
                            state_d = FETCH;
                        end
                    endcase
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    if (is_store) begin
                        z_d = (alu_res == '0);
                        if (alu_sets_carry(ir_q[6:4])) begin
                            c_d = alu_carry;
                        end
                    end else begin
                        push_en  = 1'b1;
                        push_val = dmem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    // Stack shift: push drops the bottom level, pop refills it with zero
    always_comb begin
        for (int i = 0; i < STACK_D; i++) begin
            stk_d[i] = stk_q[i];
        end
        if (push_en) begin
            stk_d[0] = push_val;
            for (int i = 1; i < STACK_D; i++) begin
                stk_d[i] = stk_q[i-1];
            end
        end else if (pop_en) begin
            for (int i = 0; i < STACK_D - 1; i++) begin
                stk_d[i] = stk_q[i+1];
            end
            stk_d[STACK_D-1] = '0;
        end
    end

    // State registers; reset aborts any in-flight access without committing
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            for (int i = 0; i < STACK_D; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            c_q     <= c_d;
            z_q     <= z_d;
            for (int i = 0; i < STACK_D; i++) begin
                stk_q[i] <= stk_d[i];
            end
        end
    end

endmodule
